// File: rtl/regfile_wb_arbiter.sv
// Purpose: shares the register-file write port among NREQ writeback producers (round-robin) and tracks pending writes.
// Latency: 1 cycle from an accepted handshake to wb_addr/wb_data, which are driven straight from flops.
// Backpressure: losing requesters see req_ready=0 and hold; zero-address requests are always accepted and dropped.
// Optional: define WB_ARB_STATS_EN to build the contention-cycle counter behind stat_out (tied to 0 otherwise).
module regfile_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic                     alloc_valid,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic [ADDR_W-1:0]        wb_addr,
    output logic [DATA_W-1:0]        wb_data,
    output logic [31:0]              busy,
    output logic [31:0]              stat_out
);

    localparam int PTR_W = (NREQ > 2) ? 2 : 1;

    logic [ADDR_W-1:0] addr_a [NREQ];
    logic [DATA_W-1:0] data_a [NREQ];
    logic [NREQ-1:0]   cand;
    logic [NREQ-1:0]   zero_req;
    logic [NREQ-1:0]   grant;

    logic              found;
    logic [PTR_W-1:0]  win_idx;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [31:0]       busy_q, busy_d;

    // Unpack the flat request buses and split requesters into real candidates and zero-address drops.
    always_comb begin
        cand     = '0;
        zero_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i]   = req_addr[i*ADDR_W +: ADDR_W];
            data_a[i]   = req_data[i*DATA_W +: DATA_W];
            cand[i]     = req_valid[i] && (addr_a[i] != '0);
            zero_req[i] = req_valid[i] && (addr_a[i] == '0);
        end
    end

    // Round-robin search: try priority slots rr_ptr, rr_ptr+1, ... (mod NREQ); first candidate wins.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        win_addr = '0;
        win_data = '0;
        grant    = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && cand[i] && (i == (int'(rr_ptr_q) + k) % NREQ)) begin
                    found    = 1'b1;
                    win_idx  = PTR_W'(i);
                    win_addr = addr_a[i];
                    win_data = data_a[i];
                    grant[i] = 1'b1;
                end
            end
        end
    end

    // Zero-address requests are acknowledged outside arbitration; nothing is acknowledged during reset.
    assign req_ready = rst ? (grant | zero_req) : '0;

    // Next state: load the winner into the write port, advance the pointer past it, update the scoreboard.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wb_addr_d = '0;
        wb_data_d = wb_data_q;
        if (found) begin
            wb_addr_d = win_addr;
            wb_data_d = win_data;
            rr_ptr_d  = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
        busy_d = busy_q;
        // The write presented next cycle retires its pending bit on the same edge.
        if (wb_addr_d != '0) begin
            busy_d[wb_addr_d] = 1'b0;
        end
        // A new reservation applied last so it survives a simultaneous retire of the older producer.
        if (alloc_valid && (alloc_addr != '0)) begin
            busy_d[alloc_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q  <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
    assign busy    = busy_q;

`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_q, stat_d;

    // Count cycles in which two or more candidates contended for the port; wraps naturally.
    always_comb begin
        stat_d = stat_q;
        if ((cand & (cand - 1'b1)) != '0) begin
            stat_d = stat_q + 32'd1;
        end
    end

    // Statistics register, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_out = stat_q;
`else
    assign stat_out = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations plus a per-cycle model compare.
// Latency: the model updates on each posedge; DUT outputs are compared on the following negedge.
// Backpressure: requesters hold address/data while not ready and drop valid after their grant.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        alloc_valid;
    logic [4:0]  alloc_addr;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] busy;
    logic [31:0] stat_out;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    regfile_wb_arbiter #(.NREQ(3), .DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .busy        (busy),
        .stat_out    (stat_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ptr     = 0;
    logic [4:0]  m_wb_addr = '0;
    logic [31:0] m_wb_data = '0;
    logic [31:0] m_busy    = '0;
    int unsigned m_stat    = 0;

    function automatic logic [4:0] addr_of(input int i);
        return req_addr[i*5 +: 5];
    endfunction

    function automatic logic [31:0] data_of(input int i);
        return req_data[i*32 +: 32];
    endfunction

    function automatic bit is_cand(input int i);
        return req_valid[i] && (addr_of(i) != 5'd0);
    endfunction

    // Whoever holds a real request and sits first in rotation order starting at the pointer.
    function automatic int pick();
        for (int k = 0; k < 3; k++) begin
            if (is_cand((m_ptr + k) % 3)) return (m_ptr + k) % 3;
        end
        return -1;
    endfunction

    function automatic int ncand();
        int n = 0;
        for (int i = 0; i < 3; i++) if (is_cand(i)) n++;
        return n;
    endfunction

    function automatic logic [2:0] exp_ready();
        logic [2:0] r = 3'b000;
        int w;
        if (!rst) return 3'b000;
        w = pick();
        for (int i = 0; i < 3; i++) if (req_valid[i] && addr_of(i) == 5'd0) r[i] = 1'b1;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin : model_upd
        int w;
        if (!rst) begin
            m_ptr = 0; m_wb_addr = '0; m_wb_data = '0; m_busy = '0; m_stat = 0;
        end else begin
            w = pick();
            if (ncand() > 1) m_stat = m_stat + 1;
            if (w >= 0) begin
                m_wb_addr = addr_of(w);
                m_wb_data = data_of(w);
                m_ptr     = (w + 1) % 3;
                m_busy[m_wb_addr] = 1'b0;
            end else begin
                m_wb_addr = '0;
            end
            if (alloc_valid && alloc_addr != 5'd0) m_busy[alloc_addr] = 1'b1;
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_ready",   {61'd0, req_ready}, {61'd0, exp_ready()});
            chk("cyc_wb_addr", {59'd0, wb_addr},   {59'd0, m_wb_addr});
            chk("cyc_wb_data", {32'd0, wb_data},   {32'd0, m_wb_data});
            chk("cyc_busy",    {32'd0, busy},      {32'd0, m_busy});
`ifdef WB_ARB_STATS_EN
            chk("cyc_stat",    {32'd0, stat_out},  {32'd0, m_stat});
`else
            chk("cyc_stat",    {32'd0, stat_out},  64'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]        = v;
        req_addr[i*5 +: 5]  = a;
        req_data[i*32 +: 32] = d;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        alloc_valid = 1'b0; alloc_addr = '0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        chk("reset_wb_addr", {59'd0, wb_addr}, 64'd0);
        chk("reset_wb_data", {32'd0, wb_data}, 64'd0);
        chk("reset_busy",    {32'd0, busy},    64'd0);
        chk("reset_stat",    {32'd0, stat_out}, 64'd0);
        rst = 1'b1;

        // Reset in the middle of operation.
        alloc_valid = 1'b1; alloc_addr = 5'd6;
        cyc();
        alloc_valid = 1'b0;
        chk("alloc6_busy", {32'd0, busy}, 64'h40);
        set_req(0, 1'b1, 5'd5, 32'h5555_0000);
        #1 chk("r0_ready", {61'd0, req_ready}, 64'b001);
        cyc();
        chk("r0_wb_addr", {59'd0, wb_addr}, 64'd5);
        #1 rst = 1'b0;
        #1;
        chk("async_wb_addr", {59'd0, wb_addr}, 64'd0);
        chk("async_busy",    {32'd0, busy},    64'd0);
        chk("async_ready",   {61'd0, req_ready}, 64'd0);
        cyc();
        cyc();

        // Release with all three contending: grants 0,1,2,0,1,2.
        rst = 1'b1;
        set_req(0, 1'b1, 5'd1, 32'hA000_0001);
        set_req(1, 1'b1, 5'd2, 32'hA000_0002);
        set_req(2, 1'b1, 5'd3, 32'hA000_0003);
        for (int k = 0; k < 6; k++) begin
            logic [2:0] oh;
            oh = 3'b001 << (k % 3);
            #1 chk("rr_ready", {61'd0, req_ready}, {61'd0, oh});
            cyc();
            chk("rr_wb_addr", {59'd0, wb_addr}, 64'(k % 3 + 1));
            chk("rr_wb_data", {32'd0, wb_data}, 64'(32'hA000_0001 + k % 3));
        end
`ifdef WB_ARB_STATS_EN
        chk("rr_stat", {32'd0, stat_out}, 64'd6);
`endif
        req_valid = '0;

        // Single requester.
        set_req(1, 1'b1, 5'd7, 32'hDEAD_BEEF);
        #1 chk("single_ready", {61'd0, req_ready}, 64'b010);
        cyc();
        chk("single_wb_addr", {59'd0, wb_addr}, 64'd7);
        chk("single_wb_data", {32'd0, wb_data}, 64'hDEAD_BEEF);
        set_req(1, 1'b0, 5'd0, 32'd0);
        cyc();
        chk("single_idle_addr", {59'd0, wb_addr}, 64'd0);
        chk("single_hold_data", {32'd0, wb_data}, 64'hDEAD_BEEF);

        // Zero-address request alongside a real one.
        set_req(0, 1'b1, 5'd0, 32'h0000_1234);
        set_req(2, 1'b1, 5'd4, 32'h4444_4444);
        #1 chk("zero_ready", {61'd0, req_ready}, 64'b101);
        cyc();
        chk("zero_wb_addr", {59'd0, wb_addr}, 64'd4);
        chk("zero_wb_data", {32'd0, wb_data}, 64'h4444_4444);
        req_valid = '0;

        // Hold under contention; order 0,1,2 also shows the pointer wrapped to 0.
        set_req(0, 1'b1, 5'd11, 32'h1111_1111);
        set_req(1, 1'b1, 5'd12, 32'h2222_2222);
        set_req(2, 1'b1, 5'd3,  32'h3333_3333);
        for (int k = 0; k < 3; k++) begin
            logic [2:0] oh;
            logic [4:0] ea;
            logic [31:0] ed;
            oh = 3'b001 << k;
            ea = (k == 0) ? 5'd11 : (k == 1) ? 5'd12 : 5'd3;
            ed = (k == 0) ? 32'h1111_1111 : (k == 1) ? 32'h2222_2222 : 32'h3333_3333;
            #1 chk("hold_ready", {61'd0, req_ready}, {61'd0, oh});
            cyc();
            chk("hold_wb_addr", {59'd0, wb_addr}, {59'd0, ea});
            chk("hold_wb_data", {32'd0, wb_data}, {32'd0, ed});
            set_req(k, 1'b0, 5'd0, 32'd0);
        end

        // Scoreboard set, clear, and set-wins collision.
        alloc_valid = 1'b1; alloc_addr = 5'd9;
        cyc();
        alloc_valid = 1'b0;
        chk("sb_set", {32'd0, busy}, 64'h200);
        set_req(1, 1'b1, 5'd9, 32'h9999_0001);
        cyc();
        chk("sb_clr_addr", {59'd0, wb_addr}, 64'd9);
        chk("sb_clr_busy", {32'd0, busy}, 64'd0);
        set_req(1, 1'b0, 5'd0, 32'd0);
        alloc_valid = 1'b1; alloc_addr = 5'd9;
        cyc();
        chk("sb_set2", {32'd0, busy}, 64'h200);
        set_req(1, 1'b1, 5'd9, 32'h9999_0002);
        cyc();
        chk("sb_both_addr", {59'd0, wb_addr}, 64'd9);
        chk("sb_set_wins", {32'd0, busy}, 64'h200);
        set_req(1, 1'b0, 5'd0, 32'd0);
        alloc_valid = 1'b0;
        cyc();
        set_req(1, 1'b1, 5'd9, 32'h9999_0003);
        cyc();
        chk("sb_final_clr", {32'd0, busy}, 64'd0);
        set_req(1, 1'b0, 5'd0, 32'd0);
        cyc();
        cyc();

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NREQ writeback producers: ALU pipe (req 0), load unit (req 1) and mul/div unit (req 2).
- Round-robin arbitration with a valid/ready handshake per requester.
- Drives the write port from registered outputs.
- Keeps a 32-entry pending-write scoreboard that the issue stage reads for hazard stalls.

Parameters:
- NREQ, 3, number of writeback requesters (2..4).
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register address width (32 registers).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  NREQ  bit i: requester i has a writeback pending.
- req_ready  out  NREQ  bit i: requester i's writeback is accepted this cycle.
- req_addr  in  NREQ*ADDR_W  destination register; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_data  in  NREQ*DATA_W  write data; requester i uses slice [i*DATA_W +: DATA_W].
- alloc_valid  in  1  issue stage reserves a destination register this cycle.
- alloc_addr  in  ADDR_W  register being reserved.
- wb_addr  out  ADDR_W  to register file write address; 0 means no write.
- wb_data  out  DATA_W  to register file write data.
- busy  out  32  scoreboard; bit r = 1 while a write to r is outstanding.
- stat_out  out  32  statistics readout (see Optional Feature).

Behaviour:
- Reset (rst low, asynchronous):
  - wb_addr=0, wb_data=0, busy=0, stat_out=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 while reset is asserted.
- Arbitration is combinational each cycle:
  - Candidates are requesters with req_valid=1 and req_addr!=0.
  - Search starts at rr_ptr, ascending with wrap modulo NREQ. The first candidate found is the winner; its req_ready=1.
- Zero-address requests:
  - A requester with req_valid=1 and req_addr=0 gets req_ready=1 in the same cycle, independent of arbitration.
  - It is discarded: no write, no pointer change.
- All other requesters have req_ready=0.
- Transfer occurs when req_valid && req_ready. Requesters must hold addr/data stable while valid && !ready.
- On the posedge after a transfer:
  - wb_addr/wb_data are loaded with the winner's addr/data, giving exactly 1 cycle latency from acceptance to the write port.
  - rr_ptr = (winner+1) mod NREQ.
- In a cycle with no winner:
  - wb_addr is loaded with 0 and wb_data holds its value. The register file sees no write.
  - rr_ptr is unchanged.
- Throughput is one writeback per cycle sustained; the port is never idle while any candidate is present.
- Fairness: with all NREQ requesters continuously valid, grants go 0,1,2,0,1,2,...; no requester waits more than NREQ-1 cycles.
- Scoreboard:
  - On posedge, if alloc_valid && alloc_addr!=0, set busy[alloc_addr].
  - On the posedge that loads wb_addr=r (r!=0), clear busy[r].
  - If set and clear hit the same register in the same cycle, set wins (a newer producer is pending).
  - busy[0] is constant 0.
  - Writes to non-busy registers are legal and leave busy unchanged.
- Forwarding within the register file covers the write cycle itself. busy therefore deasserts in the same cycle wb_addr presents the write.

Optional Feature:
- Macro WB_ARB_STATS_EN.
- Defined:
  - stat_out is a free-running 32-bit count of conflict cycles, defined as cycles where more than one candidate was valid.
  - The count wraps at 2^32 and is cleared by reset.
- Undefined:
  - No counter logic is built.
  - stat_out is tied to 0.

Test Plan:
- Reset mid-operation: req0 valid addr=5 granted, then rst low before the next posedge -> wb_addr=0 and busy=0 immediately (async); after release the first grant goes to req0 (rr_ptr=0).
- Single requester: req1 valid addr=7 data=0xDEADBEEF -> req_ready[1]=1 the same cycle; next cycle wb_addr=7, wb_data=0xDEADBEEF; the cycle after, wb_addr=0.
- All three valid for 6 cycles (addrs 1,2,3) -> grant order 0,1,2,0,1,2; wb_addr sequence 1,2,3,1,2,3; with WB_ARB_STATS_EN, stat_out=6.
- Zero address: req0 valid addr=0 and req2 valid addr=4 -> req_ready=3'b101; next cycle wb_addr=4; rr_ptr=0 (advanced past req2).
- Scoreboard: alloc addr=9 -> busy[9]=1 next cycle; req1 writes 9 -> busy[9]=0 the cycle wb_addr=9; alloc 9 in the same cycle as that write -> busy[9] stays 1.
- Hold under contention: req2 valid addr=3 while req0 and req1 are granted -> req2 keeps data stable and is granted by the 3rd cycle with correct wb_data.
